// File: rtl/man_ctrl_pipe.sv
// Elastic valid/ready pipeline carrying MAN state, RAM2 write-enable and RAM2 address
// through DEPTH register stages, with synchronous flush and an occupancy count.
module man_ctrl_pipe #(
   parameter int                 STATE_W     = 2,
   parameter int                 ADDR_W      = 20,
   parameter int                 DEPTH       = 2,
   parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [STATE_W-1:0]           in_state,
   input  logic                         in_we,
   input  logic [ADDR_W-1:0]            in_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [STATE_W-1:0]           out_state,
   output logic                         out_we,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]   vld;
   logic [DEPTH-1:0]   we_q;
   logic [STATE_W-1:0] state_q [DEPTH];
   logic [ADDR_W-1:0]  addr_q  [DEPTH];
   logic [DEPTH-1:0]   rdy;
   logic               take_in;

   // A stage can load when any stage at or after it is empty, or the sink accepts.
   // This is the unrolled form of ready_i = !valid_i | ready_(i+1).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rdy[i] = out_ready;
         for (int j = i; j < DEPTH; j++) begin
            if (!vld[j]) rdy[i] = 1'b1;
         end
      end
   end

   assign in_ready = rdy[0] & ~flush;
   assign take_in  = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= '0;
         we_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= RESET_STATE;
            addr_q[i]  <= '0;
         end
      end else if (flush) begin
         vld <= '0;
      end else begin
         // stage 0: load from the upstream port
         if (rdy[0]) begin
            vld[0] <= take_in;
            if (take_in) begin
               state_q[0] <= in_state;
               we_q[0]    <= in_we;
               addr_q[0]  <= in_addr;
            end
         end
         // stages 1..DEPTH-1: payload only moves with a valid entry
         for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               vld[i] <= vld[i-1];
               if (vld[i-1]) begin
                  state_q[i] <= state_q[i-1];
                  we_q[i]    <= we_q[i-1];
                  addr_q[i]  <= addr_q[i-1];
               end
            end
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_we    = vld[DEPTH-1] & we_q[DEPTH-1];
   assign out_state = state_q[DEPTH-1];
   assign out_addr  = addr_q[DEPTH-1];
   assign occupancy = OCC_W'($countones(vld));

endmodule
